// File: rtl/comparator_pkg.sv
// comparator_pkg: shared definitions for the comparator_stream block.
//   - 2-bit outcome codes produced by cmp_core.
//   - outcome_to_flags(): maps an outcome code onto the one-hot
//     {mayor, menor, igual} flag vector held by the result register.
package comparator_pkg;

  typedef logic [1:0] cmp_outcome_t;

  localparam cmp_outcome_t CMP_MAYOR = 2'd0;
  localparam cmp_outcome_t CMP_MENOR = 2'd1;
  localparam cmp_outcome_t CMP_IGUAL = 2'd2;

  // Flag vector bit order is {mayor, menor, igual}; an unused code maps to
  // all-zero so an illegal outcome can never look like a valid result.
  function automatic logic [2:0] outcome_to_flags(input cmp_outcome_t outcome);
    logic [2:0] flags;
    case (outcome)
      CMP_MAYOR: flags = 3'b100;
      CMP_MENOR: flags = 3'b010;
      CMP_IGUAL: flags = 3'b001;
      default:   flags = 3'b000;
    endcase
    return flags;
  endfunction

endpackage

// File: rtl/comparator_stream_cmp_core.sv
// cmp_core: purely combinational N-bit magnitude comparator.
// Ports:
//   a_i, b_i      - operands (N bits)
//   signed_i      - 1: two's-complement compare, 0: unsigned
//   outcome_o     - CMP_MAYOR / CMP_MENOR / CMP_IGUAL
module cmp_core
  import comparator_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0]  a_i,
  input  logic [N-1:0]  b_i,
  input  logic          signed_i,
  output cmp_outcome_t  outcome_o
);

  // Flipping the sign bit maps two's-complement order onto unsigned order,
  // so one unsigned comparator serves both modes (also correct for N=1).
  logic [N-1:0] msb_mask_s;
  logic [N-1:0] a_u_s;
  logic [N-1:0] b_u_s;

  assign msb_mask_s = N'(signed_i) << (N - 1);
  assign a_u_s      = a_i ^ msb_mask_s;
  assign b_u_s      = b_i ^ msb_mask_s;

  always_comb begin
    outcome_o = CMP_IGUAL;
    if (a_u_s > b_u_s) begin
      outcome_o = CMP_MAYOR;
    end else if (a_u_s < b_u_s) begin
      outcome_o = CMP_MENOR;
    end else begin
      outcome_o = CMP_IGUAL;
    end
  end

endmodule

// File: rtl/comparator_stream.sv
// comparator_stream: registered, valid/ready-handshaked magnitude comparator
// with saturating per-outcome event counters.
// Ports:
//   clk, rst               - clock, synchronous active-high reset
//   piValid / poReady      - input handshake (poReady = ~poValid | piReady)
//   piA, piB, piSigned     - operand pair and compare mode, sampled on accept
//   poValid / piReady      - output handshake
//   poMayor/poMenor/poIgual- one-hot result flags (registered)
//   piClear                - synchronous clear of the counters
//   poCntMayor/Menor/Igual - saturating outcome counters (CNT_W bits)
module comparator_stream
  import comparator_pkg::*;
#(
  parameter int N     = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             piValid,
  output logic             poReady,
  input  logic [N-1:0]     piA,
  input  logic [N-1:0]     piB,
  input  logic             piSigned,
  output logic             poValid,
  input  logic             piReady,
  output logic             poMayor,
  output logic             poMenor,
  output logic             poIgual,
  input  logic             piClear,
  output logic [CNT_W-1:0] poCntMayor,
  output logic [CNT_W-1:0] poCntMenor,
  output logic [CNT_W-1:0] poCntIgual
);

  cmp_outcome_t     outcome_s;
  logic             accept_s;
  logic             xfer_s;
  logic             valid_q,     valid_d;
  logic [2:0]       flags_q,     flags_d;
  logic [CNT_W-1:0] cnt_mayor_q, cnt_mayor_d;
  logic [CNT_W-1:0] cnt_menor_q, cnt_menor_d;
  logic [CNT_W-1:0] cnt_igual_q, cnt_igual_d;

  // Clear zeroes the base first so a pair accepted on the clear edge still
  // lands as a count of 1; all-ones holds instead of wrapping.
  function automatic logic [CNT_W-1:0] next_count(input logic [CNT_W-1:0] cur,
                                                  input logic clr,
                                                  input logic hit);
    logic [CNT_W-1:0] base;
    base = clr ? {CNT_W{1'b0}} : cur;
    if (hit && (base != {CNT_W{1'b1}})) begin
      return base + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      return base;
    end
  endfunction

  cmp_core #(.N(N)) u_cmp_core (
    .a_i       (piA),
    .b_i       (piB),
    .signed_i  (piSigned),
    .outcome_o (outcome_s)
  );

  assign poReady  = ~valid_q | piReady;
  assign accept_s = piValid & poReady;
  assign xfer_s   = valid_q & piReady;

  always_comb begin
    valid_d     = valid_q;
    flags_d     = flags_q;
    if (accept_s) begin
      valid_d = 1'b1;
      flags_d = outcome_to_flags(outcome_s);
    end else if (xfer_s) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
    cnt_mayor_d = next_count(cnt_mayor_q, piClear, accept_s && (outcome_s == CMP_MAYOR));
    cnt_menor_d = next_count(cnt_menor_q, piClear, accept_s && (outcome_s == CMP_MENOR));
    cnt_igual_d = next_count(cnt_igual_q, piClear, accept_s && (outcome_s == CMP_IGUAL));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= 1'b0;
      flags_q     <= 3'b000;
      cnt_mayor_q <= {CNT_W{1'b0}};
      cnt_menor_q <= {CNT_W{1'b0}};
      cnt_igual_q <= {CNT_W{1'b0}};
    end else begin
      valid_q     <= valid_d;
      flags_q     <= flags_d;
      cnt_mayor_q <= cnt_mayor_d;
      cnt_menor_q <= cnt_menor_d;
      cnt_igual_q <= cnt_igual_d;
    end
  end

  assign poValid    = valid_q;
  assign poMayor    = flags_q[2];
  assign poMenor    = flags_q[1];
  assign poIgual    = flags_q[0];
  assign poCntMayor = cnt_mayor_q;
  assign poCntMenor = cnt_menor_q;
  assign poCntIgual = cnt_igual_q;

endmodule

// File: tb/tb_comparator_stream.sv
// tb_comparator_stream: directed + random bench for comparator_stream.
// Two instances share stimulus: CNT_W=16 (main) and CNT_W=4 (saturation).
// The reference model works on integer operand values and plain counters.
module tb_comparator_stream;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst, piValid, piSigned, piReady, piClear;
  logic [N-1:0] piA, piB;

  logic        rdy16, val16, may16, men16, igu16;
  logic [15:0] cm16, cl16, ci16;
  logic        rdy4, val4, may4, men4, igu4;
  logic [3:0]  cm4, cl4, ci4;

  int errors = 0;
  int checks = 0;

  // Reference model state: 0 = mayor, 1 = menor, 2 = igual
  bit m_valid;
  bit [2:0] m_flags;
  int m_c16 [3];
  int m_c4 [3];

  comparator_stream #(.N(N), .CNT_W(16)) dut16 (
    .clk(clk), .rst(rst), .piValid(piValid), .poReady(rdy16), .piA(piA), .piB(piB),
    .piSigned(piSigned), .poValid(val16), .piReady(piReady), .poMayor(may16),
    .poMenor(men16), .poIgual(igu16), .piClear(piClear),
    .poCntMayor(cm16), .poCntMenor(cl16), .poCntIgual(ci16)
  );

  comparator_stream #(.N(N), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .piValid(piValid), .poReady(rdy4), .piA(piA), .piB(piB),
    .piSigned(piSigned), .poValid(val4), .piReady(piReady), .poMayor(may4),
    .poMenor(men4), .poIgual(igu4), .piClear(piClear),
    .poCntMayor(cm4), .poCntMenor(cl4), .poCntIgual(ci4)
  );

  always #5 clk = ~clk;

  function automatic int ref_outcome(input logic [N-1:0] a, input logic [N-1:0] b, input logic s);
    int va, vb;
    va = int'(a);
    vb = int'(b);
    if (s && va >= (1 << (N - 1))) va = va - (1 << N);
    if (s && vb >= (1 << (N - 1))) vb = vb - (1 << N);
    if (va > vb) return 0;
    if (va < vb) return 1;
    return 2;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: check ready, advance the model, clock, check all outputs.
  task automatic tick();
    bit acc;
    int o;
    #1;
    chk("ready16", 32'(rdy16), 32'(!m_valid || piReady));
    chk("ready4",  32'(rdy4),  32'(!m_valid || piReady));
    if (rst) begin
      m_valid = 1'b0;
      m_flags = 3'b000;
      for (int i = 0; i < 3; i++) begin m_c16[i] = 0; m_c4[i] = 0; end
    end else begin
      acc = piValid && (!m_valid || piReady);
      o = ref_outcome(piA, piB, piSigned);
      if (acc) begin
        m_valid = 1'b1;
        m_flags = {o == 0, o == 1, o == 2};
      end else if (m_valid && piReady) begin
        m_valid = 1'b0;
      end
      if (piClear) for (int i = 0; i < 3; i++) begin m_c16[i] = 0; m_c4[i] = 0; end
      if (acc) begin
        if (m_c16[o] < 65535) m_c16[o]++;
        if (m_c4[o] < 15) m_c4[o]++;
      end
    end
    @(posedge clk);
    #1;
    chk("valid16", 32'(val16), 32'(m_valid));
    chk("flags16", 32'({may16, men16, igu16}), 32'(m_flags));
    chk("cnt_mayor16", 32'(cm16), 32'(m_c16[0]));
    chk("cnt_menor16", 32'(cl16), 32'(m_c16[1]));
    chk("cnt_igual16", 32'(ci16), 32'(m_c16[2]));
    chk("valid4", 32'(val4), 32'(m_valid));
    chk("flags4", 32'({may4, men4, igu4}), 32'(m_flags));
    chk("cnt_mayor4", 32'(cm4), 32'(m_c4[0]));
    chk("cnt_menor4", 32'(cl4), 32'(m_c4[1]));
    chk("cnt_igual4", 32'(ci4), 32'(m_c4[2]));
  endtask

  task automatic drive(input bit v, input logic [N-1:0] a, input logic [N-1:0] b, input bit s);
    piValid = v; piA = a; piB = b; piSigned = s;
  endtask

  initial begin
    int base;
    rst = 1'b1; piValid = 1'b0; piA = '0; piB = '0; piSigned = 1'b0;
    piReady = 1'b1; piClear = 1'b0;
    m_valid = 1'b0; m_flags = 3'b000;
    for (int i = 0; i < 3; i++) begin m_c16[i] = 0; m_c4[i] = 0; end

    // Reset then idle
    tick(); tick();
    rst = 1'b0;
    tick(); tick();
    chk("idle_valid", 32'(val16), 32'd0);
    chk("idle_flags", 32'({may16, men16, igu16}), 32'd0);
    chk("idle_ready", 32'(rdy16), 32'd1);

    // Unsigned vs signed on the same pair
    drive(1'b1, 8'hF0, 8'h10, 1'b0); tick();
    chk("unsigned_mayor", 32'(may16), 32'd1);
    drive(1'b1, 8'hF0, 8'h10, 1'b1); tick();
    chk("signed_menor", 32'(men16), 32'd1);
    drive(1'b0, 8'h00, 8'h00, 1'b0); tick();
    chk("us_cnt_mayor", 32'(cm16), 32'd1);
    chk("us_cnt_menor", 32'(cl16), 32'd1);

    // Back-pressure: stall three cycles with a pending pair
    drive(1'b1, 8'd5, 8'd5, 1'b0); tick();
    drive(1'b1, 8'd9, 8'd2, 1'b0); piReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_igual", 32'({may16, men16, igu16}), 32'b001);
      chk("stall_ready", 32'(rdy16), 32'd0);
    end
    piReady = 1'b1; tick();
    chk("post_stall_mayor", 32'({val16, may16}), 32'b11);
    drive(1'b0, 8'd0, 8'd0, 1'b0); tick();
    chk("bp_cnt_mayor", 32'(cm16), 32'd2);
    chk("bp_cnt_igual", 32'(ci16), 32'd1);

    // Streaming: 100 back-to-back random pairs
    base = m_c16[0] + m_c16[1] + m_c16[2];
    for (int i = 0; i < 100; i++) begin
      drive(1'b1, N'($urandom), N'($urandom), 1'($urandom));
      tick();
    end
    drive(1'b0, 8'd0, 8'd0, 1'b0); tick();
    chk("stream_sum", 32'(cm16) + 32'(cl16) + 32'(ci16), 32'(base + 100));

    // Saturation on the 4-bit counters
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 8'd3, 8'd7, 1'($urandom)); tick();
    end
    drive(1'b0, 8'd0, 8'd0, 1'b0); tick();
    chk("sat_menor4", 32'(cl4), 32'd15);
    chk("sat_mayor4", 32'(cm4), 32'd0);
    chk("sat_igual4", 32'(ci4), 32'd0);
    chk("sat_menor16", 32'(cl16), 32'd20);

    // Clear colliding with an accept
    piClear = 1'b1; drive(1'b1, 8'd0, 8'd0, 1'b0); tick();
    piClear = 1'b0; drive(1'b0, 8'd0, 8'd0, 1'b0);
    chk("clr_igual", 32'(ci16), 32'd1);
    chk("clr_mayor", 32'(cm16), 32'd0);
    chk("clr_menor", 32'(cl16), 32'd0);

    // Reset in the middle of a stall
    piReady = 1'b0; drive(1'b1, 8'h80, 8'h7F, 1'b1); tick(); tick();
    chk("pre_rst_valid", 32'(val16), 32'd1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst_stall_valid", 32'(val16), 32'd0);
    drive(1'b0, 8'd0, 8'd0, 1'b0); piReady = 1'b1; tick();

    // Random mix of valid, ready and clear
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 3) != 0), N'($urandom), N'($urandom), 1'($urandom));
      piReady = 1'($urandom_range(0, 2) != 0);
      piClear = 1'($urandom_range(0, 19) == 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
